// File: rtl/velmcollector_jump_pkg.sv
// Shared vector-unit definitions: collector FSM states, element order and count sizing.
package velmcollector_jump_pkg;

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    // Element order within a two-element beat.
    localparam int OLD = 0;
    localparam int NEW = 1;

    function automatic int cnt_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/velmcollector_shiftreg.sv
// Lane shift register: each lane holds {fill, mask, data}; shifts 1 or 2 lanes left or right.
// Clear drops mask and fill flags but leaves data in place.
module velmcollector_shiftreg #(
    parameter int NUMLANES = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      shift,
    input  logic                      jump,
    input  logic                      left,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          e0_dat,
    input  logic [WIDTH-1:0]          e1_dat,
    input  logic                      e0_sq,
    input  logic                      e1_sq,
    output logic [NUMLANES*WIDTH-1:0] lane_dat,
    output logic [NUMLANES-1:0]       lane_mask
);

    localparam int LW = WIDTH + 2;
    localparam int RW = NUMLANES * LW;

    logic [RW-1:0] r;
    logic [RW-1:0] r_nxt;
    logic [RW-1:0] keep;
    logic [LW-1:0] e0;
    logic [LW-1:0] e1;

    assign e0 = {1'b1, ~e0_sq, e0_dat};
    assign e1 = {1'b1, ~e1_sq, e1_dat};

    always_comb begin
        keep = '0;
        for (int i = 0; i < NUMLANES; i++) begin
            keep[i*LW +: LW] = {2'b00, {WIDTH{1'b1}}};
        end
    end

    // Left entries land at lane 0 (newest lowest); right entries land at the top lane.
    always_comb begin
        r_nxt = r;
        if (shift) begin
            case ({left, jump})
                2'b10:   r_nxt = (r << LW) | RW'(e0);
                2'b11:   r_nxt = (r << (2*LW)) | RW'({e0, e1});
                2'b00:   r_nxt = (r >> LW) | (RW'(e0) << ((NUMLANES-1)*LW));
                default: r_nxt = (r >> (2*LW)) | (RW'({e1, e0}) << ((NUMLANES-2)*LW));
            endcase
        end else if (clear) begin
            r_nxt = r & keep;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r <= '0;
        end else begin
            r <= r_nxt;
        end
    end

    always_comb begin
        lane_dat  = '0;
        lane_mask = '0;
        for (int i = 0; i < NUMLANES; i++) begin
            lane_dat[i*WIDTH +: WIDTH] = r[i*LW +: WIDTH];
            lane_mask[i]               = r[i*LW + WIDTH] & r[i*LW + WIDTH + 1];
        end
    end

endmodule

// File: rtl/velmcollector_jump.sv
// Collects 1- or 2-element beats into a lane vector and presents it on a valid/ready port.
// Output valid one cycle after the completing beat; input stalls for the whole HOLD state.
module velmcollector_jump
    import velmcollector_jump_pkg::*;
#(
    parameter int NUMLANES = 4,
    parameter int WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_jump,
    input  logic                              in_dir_left,
    input  logic [1:0]                        in_squash,
    input  logic                              in_last,
    input  logic [2*WIDTH-1:0]                in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUMLANES*WIDTH-1:0]         out_data,
    output logic [NUMLANES-1:0]               out_mask,
    output logic [cnt_width(NUMLANES)-1:0]    out_count
);

    localparam int CW  = cnt_width(NUMLANES);
    localparam int CW1 = CW + 1;

    state_t         state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic           dir, dir_nxt;
    logic [CW1-1:0] sum;
    logic           dir_use;
    logic           shift;
    logic           clear;

    assign sum     = CW1'(count) + CW1'(in_jump) + CW1'(1);
    assign dir_use = (count == '0) ? in_dir_left : dir;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        dir_nxt   = dir;
        in_ready  = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;
        case (state)
            FILL: begin
                in_ready = (sum <= CW1'(NUMLANES));
                if (in_valid && in_ready) begin
                    shift     = 1'b1;
                    dir_nxt   = dir_use;
                    count_nxt = sum[CW-1:0];
                    if (sum == CW1'(NUMLANES) || in_last) begin
                        state_nxt = HOLD;
                    end
                end else if (in_valid && in_jump && count == CW'(NUMLANES-1)) begin
                    // A pair that cannot fit flushes the partial vector and waits.
                    state_nxt = HOLD;
                end
            end
            default: begin
                if (out_ready) begin
                    state_nxt = FILL;
                    count_nxt = '0;
                    clear     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= FILL;
            count <= '0;
            dir   <= 1'b1;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

    velmcollector_shiftreg #(
        .NUMLANES (NUMLANES),
        .WIDTH    (WIDTH)
    ) u_shiftreg (
        .clk       (clk),
        .resetn    (resetn),
        .shift     (shift),
        .jump      (in_jump),
        .left      (dir_use),
        .clear     (clear),
        .e0_dat    (in_data[OLD*WIDTH +: WIDTH]),
        .e1_dat    (in_data[NEW*WIDTH +: WIDTH]),
        .e0_sq     (in_squash[OLD]),
        .e1_sq     (in_squash[NEW]),
        .lane_dat  (out_data),
        .lane_mask (out_mask)
    );

    assign out_valid = (state == HOLD);
    assign out_count = count;

endmodule

// File: tb/tb_velmcollector_jump.sv
// Directed bench for velmcollector_jump with a lane-by-lane model feeding an expectation queue.
module tb_velmcollector_jump;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           resetn;
    logic           in_valid;
    logic           in_ready;
    logic           in_jump;
    logic           in_dir_left;
    logic [1:0]     in_squash;
    logic           in_last;
    logic [2*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_mask;
    logic [2:0]     out_count;

    velmcollector_jump #(.NUMLANES(N), .WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_jump     (in_jump),
        .in_dir_left (in_dir_left),
        .in_squash   (in_squash),
        .in_last     (in_last),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] dat;
        logic [N-1:0]   msk;
        logic [N-1:0]   fil;
        logic [2:0]     cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: one element at a time enters the lane array.
    logic [W-1:0] m_dat [N];
    logic         m_msk [N];
    logic         m_fil [N];
    int           m_cnt;
    logic         m_dir;

    localparam logic [W-1:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
    localparam logic [W-1:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;
    localparam logic [W-1:0] G = 32'h6060_0007;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_dat[i] = '0;
            m_msk[i] = 1'b0;
            m_fil[i] = 1'b0;
        end
        m_cnt = 0;
        m_dir = 1'b1;
    endtask

    task automatic model_elem(input logic [W-1:0] d, input logic sq, input logic left);
        if (left) begin
            for (int i = N-1; i > 0; i--) begin
                m_dat[i] = m_dat[i-1]; m_msk[i] = m_msk[i-1]; m_fil[i] = m_fil[i-1];
            end
            m_dat[0] = d; m_msk[0] = ~sq; m_fil[0] = 1'b1;
        end else begin
            for (int i = 0; i < N-1; i++) begin
                m_dat[i] = m_dat[i+1]; m_msk[i] = m_msk[i+1]; m_fil[i] = m_fil[i+1];
            end
            m_dat[N-1] = d; m_msk[N-1] = ~sq; m_fil[N-1] = 1'b1;
        end
    endtask

    task automatic model_emit();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.dat[i*W +: W] = m_fil[i] ? m_dat[i] : '0;
            e.msk[i]        = m_msk[i] & m_fil[i];
            e.fil[i]        = m_fil[i];
            m_msk[i]        = 1'b0;
            m_fil[i]        = 1'b0;
        end
        e.cnt = 3'(m_cnt);
        sb.push_back(e);
        m_cnt = 0;
    endtask

    function automatic logic [N*W-1:0] lane_sel(input logic [N-1:0] fil);
        logic [N*W-1:0] m;
        for (int i = 0; i < N; i++) m[i*W +: W] = {W{fil[i]}};
        return m;
    endfunction

    task automatic drain();
        exp_t e;
        int t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); @(negedge clk); t++;
        end
        check("drain_valid", out_valid, 1'b1);
        check("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_data", out_data & lane_sel(e.fil), e.dat);
            check("out_mask", out_mask, e.msk);
            check("out_count", out_count, e.cnt);
            check("hold_in_ready", in_ready, 1'b0);
            @(posedge clk); @(negedge clk);
            check("hold_stable_valid", out_valid, 1'b1);
            check("hold_stable_mask", out_mask, e.msk);
            check("hold_stable_count", out_count, e.cnt);
        end
        out_ready = 1'b1;
        #1;
        check("bubble_in_ready", in_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("post_drain_valid", out_valid, 1'b0);
        check("post_drain_mask", out_mask, '0);
        check("post_drain_count", out_count, '0);
    endtask

    task automatic send(input logic jump, input logic left, input logic [1:0] sq,
                        input logic last, input logic [W-1:0] d0, input logic [W-1:0] d1);
        logic done = 1'b0;
        logic lu;
        logic complete;
        int   n = jump ? 2 : 1;
        in_valid    = 1'b1;
        in_jump     = jump;
        in_dir_left = left;
        in_squash   = sq;
        in_last     = last;
        in_data     = {d1, d0};
        for (int t = 0; t < 30 && !done; t++) begin
            #1;
            check("in_ready", in_ready, (m_cnt + n <= N));
            if (m_cnt + n <= N) begin
                lu = (m_cnt == 0) ? left : m_dir;
                m_dir = lu;
                model_elem(d0, sq[0], lu);
                if (jump) model_elem(d1, sq[1], lu);
                m_cnt += n;
                complete = (m_cnt == N) || last;
                if (complete) model_emit();
                @(posedge clk); @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                check("fill_to_valid", out_valid, complete);
                done = 1'b1;
            end else begin
                model_emit();
                @(posedge clk); @(negedge clk);
                check("autoflush_valid", out_valid, 1'b1);
                drain();
            end
        end
        check("send_done", done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_jump = 1'b0; in_dir_left = 1'b1;
        in_squash = '0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", out_count, '0);
        check("rst_mask", out_mask, '0);
        check("rst_data", out_data, '0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        // Four left singles; later beats' direction must be ignored.
        send(0, 1, 2'b00, 0, A, 0);
        send(0, 0, 2'b00, 0, B, 0);
        send(0, 0, 2'b00, 0, C, 0);
        send(0, 1, 2'b00, 0, D, 0);
        drain();

        // Right-shifting pairs.
        send(1, 0, 2'b00, 0, A, B);
        send(1, 0, 2'b00, 0, C, D);
        drain();

        // Pair arriving with one lane left flushes the partial vector first.
        send(0, 1, 2'b00, 0, A, 0);
        send(0, 1, 2'b00, 0, B, 0);
        send(0, 1, 2'b00, 0, C, 0);
        send(1, 1, 2'b00, 0, D, E);
        send(1, 1, 2'b00, 0, F, G);
        drain();

        // Single-element vectors terminated by in_last, both directions.
        send(0, 1, 2'b00, 1, A, 0);
        drain();
        send(0, 0, 2'b01, 1, B, 0);
        drain();

        // Squashed newer element of a pair.
        send(1, 1, 2'b10, 0, A, B);
        send(0, 1, 2'b00, 0, C, 0);
        send(0, 1, 2'b00, 0, D, 0);
        drain();

        // Reset mid-vector discards everything.
        send(0, 1, 2'b00, 0, E, 0);
        send(0, 1, 2'b00, 0, F, 0);
        send(0, 1, 2'b00, 0, G, 0);
        resetn = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_count", out_count, '0);
        check("midrst_mask", out_mask, '0);
        @(posedge clk); @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check("midrst_data", out_data, '0);
        send(0, 1, 2'b00, 0, A, 0);
        send(0, 1, 2'b00, 0, B, 0);
        send(0, 1, 2'b00, 0, C, 0);
        send(0, 1, 2'b00, 0, D, 0);
        drain();

        check("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
